// File: rtl/rf_pkg.sv
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared register-file sizing constants and the grant/priority
//                encodings used by the writeback arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;

    // Register-file geometry shared by the register file and its write arbiter
    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int NREGS = 2**AW;

    // One-hot grant encoding: bit 0 = requester A, bit 1 = requester B
    localparam logic [1:0] c_GNT_NONE = 2'b00;
    localparam logic [1:0] c_GNT_A    = 2'b01;
    localparam logic [1:0] c_GNT_B    = 2'b10;

    // Round-robin pointer values: which requester wins the next contended cycle
    localparam logic c_PRIO_A = 1'b0;
    localparam logic c_PRIO_B = 1'b1;

    // After a contended grant the loser gets priority next time
    function automatic logic prio_after(input logic [1:0] gnt);
        return gnt[0] ? c_PRIO_B : c_PRIO_A;
    endfunction

endpackage : rf_pkg

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter. Grant is purely combinational
//                from the requests and the pointer; the pointer only moves on
//                cycles where both requesters contend.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic r_prio;

    // Grant selection: a lone requester always wins, contention follows pointer
    always_comb begin
        grant = c_GNT_NONE;
        case (req)
            2'b01:   grant = c_GNT_A;
            2'b10:   grant = c_GNT_B;
            2'b11:   grant = (r_prio == c_PRIO_B) ? c_GNT_B : c_GNT_A;
            default: grant = c_GNT_NONE;
        endcase
    end

    // Pointer update: flip to the loser only when both requested
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prio <= c_PRIO_A;
        end else if (req == 2'b11) begin
            r_prio <= prio_after(grant);
        end
    end

endmodule : rr_arb2

`default_nettype wire

// File: rtl/rf_wr_arb.sv
// ============================================================================
//  Module      : rf_wr_arb
//  Description : Register-file write arbiter. Merges ALU (A) and load (B)
//                writebacks onto one registered write port with round-robin
//                arbitration, and keeps a per-register pending-write
//                scoreboard fed by issue-stage claims.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wr_arb
    import rf_pkg::*;
#(
    parameter int DW = rf_pkg::DW,
    parameter int AW = rf_pkg::AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [AW-1:0]    a_reg,
    input  logic [DW-1:0]    a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [AW-1:0]    b_reg,
    input  logic [DW-1:0]    b_data,
    input  logic             claim_valid,
    output logic             claim_ready,
    input  logic [AW-1:0]    claim_reg,
    output logic             rf_we,
    output logic [AW-1:0]    rf_write_reg,
    output logic [DW-1:0]    rf_data_in,
    output logic [2**AW-1:0] busy
);

    localparam int c_NREGS = 2**AW;

    logic [1:0]         w_req;
    logic [1:0]         w_grant;
    logic               w_xfer_a;
    logic               w_xfer_b;
    logic               w_claim_xfer;
    logic [AW-1:0]      w_sel_reg;
    logic [DW-1:0]      w_sel_data;
    logic [c_NREGS-1:0] w_clr;
    logic [c_NREGS-1:0] w_set;

    // Requests are masked in reset so neither ready can rise and the pointer holds
    assign w_req = {b_valid & rst, a_valid & rst};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (w_req),
        .grant (w_grant)
    );

    assign a_ready  = w_grant[0];
    assign b_ready  = w_grant[1];
    assign w_xfer_a = a_valid & a_ready;
    assign w_xfer_b = b_valid & b_ready;

    // At most one writeback transfers per cycle, so a simple mux picks it
    assign w_sel_reg  = w_xfer_b ? b_reg  : a_reg;
    assign w_sel_data = w_xfer_b ? b_data : a_data;

    assign claim_ready  = rst & ~busy[claim_reg];
    assign w_claim_xfer = claim_valid & claim_ready;

    // Per-register set (claim) and clear (writeback) strobes
    for (genvar n = 0; n < c_NREGS; n++) begin : g_busy
        assign w_clr[n] = (w_xfer_a && (a_reg == AW'(n))) ||
                          (w_xfer_b && (b_reg == AW'(n)));
        assign w_set[n] = w_claim_xfer && (claim_reg == AW'(n));
    end

    // Scoreboard: set after clear so a same-cycle claim keeps the bit pending
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~w_clr) | w_set;
        end
    end

    // Registered write port: strobe every cycle, address/data only on transfer
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we        <= 1'b0;
            rf_write_reg <= '0;
            rf_data_in   <= '0;
        end else begin
            rf_we <= w_xfer_a | w_xfer_b;
            if (w_xfer_a | w_xfer_b) begin
                rf_write_reg <= w_sel_reg;
                rf_data_in   <= w_sel_data;
            end
        end
    end

endmodule : rf_wr_arb

`default_nettype wire

// File: tb/tb_rf_wr_arb.sv
// ============================================================================
//  Module      : tb_rf_wr_arb
//  Description : Self-checking bench for rf_wr_arb. A reference model of the
//                arbiter pointer and busy scoreboard predicts ready signals;
//                predicted writes are queued and popped when the write port
//                should present them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wr_arb;

    localparam int DW = 32;
    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic          a_valid, b_valid, claim_valid;
    logic          a_ready, b_ready, claim_ready;
    logic [AW-1:0] a_reg, b_reg, claim_reg;
    logic [DW-1:0] a_data, b_data;
    logic          rf_we;
    logic [AW-1:0] rf_write_reg;
    logic [DW-1:0] rf_data_in;
    logic [7:0]    busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [AW+DW-1:0] sb[$];
    logic             m_prio_b;
    logic [7:0]       m_busy;
    logic [AW-1:0]    m_last_reg;
    logic [DW-1:0]    m_last_data;
    logic             g_a, g_b;

    rf_wr_arb #(.DW(DW), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_reg        (a_reg),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_reg        (b_reg),
        .b_data       (b_data),
        .claim_valid  (claim_valid),
        .claim_ready  (claim_ready),
        .claim_reg    (claim_reg),
        .rf_we        (rf_we),
        .rf_write_reg (rf_write_reg),
        .rf_data_in   (rf_data_in),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus: predict readies, queue expected writes, then pop
    // and compare the write port after the edge. Called just after a negedge.
    task automatic drive_cycle(input logic rv,
                               input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                               input logic bv, input logic [AW-1:0] br, input logic [DW-1:0] bd,
                               input logic cv, input logic [AW-1:0] cr);
        logic ea, eb, ec, ewe;
        logic [7:0] nb;
        logic [AW+DW-1:0] w;
        rst = rv; a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        claim_valid = cv; claim_reg = cr;
        #2;
        ea = rv & av & (~bv | ~m_prio_b);
        eb = rv & bv & (~av | m_prio_b);
        ec = rv & ~m_busy[cr];
        n_cmp++;
        if (a_ready !== ea) begin n_bad++; $display("FAIL a_ready t=%0t got %b exp %b", $time, a_ready, ea); end
        n_cmp++;
        if (b_ready !== eb) begin n_bad++; $display("FAIL b_ready t=%0t got %b exp %b", $time, b_ready, eb); end
        n_cmp++;
        if (claim_ready !== ec) begin n_bad++; $display("FAIL claim_ready t=%0t got %b exp %b", $time, claim_ready, ec); end
        g_a = ea; g_b = eb;
        if (!rv) begin
            sb.delete();
            m_busy = '0; m_prio_b = 1'b0; m_last_reg = '0; m_last_data = '0;
        end else begin
            if (av && bv) m_prio_b = ea;
            if (ea) sb.push_back({ar, ad});
            if (eb) sb.push_back({br, bd});
            nb = m_busy;
            if (ea) nb[ar] = 1'b0;
            if (eb) nb[br] = 1'b0;
            if (cv && ec) nb[cr] = 1'b1;
            m_busy = nb;
        end
        @(posedge clk); #1;
        if (sb.size() > 0) begin
            w = sb.pop_front();
            ewe = 1'b1; m_last_reg = w[AW+DW-1:DW]; m_last_data = w[DW-1:0];
        end else begin
            ewe = 1'b0;
        end
        n_cmp++;
        if (rf_we !== ewe) begin n_bad++; $display("FAIL rf_we t=%0t got %b exp %b", $time, rf_we, ewe); end
        n_cmp++;
        if (rf_write_reg !== m_last_reg) begin n_bad++; $display("FAIL rf_write_reg t=%0t got %0d exp %0d", $time, rf_write_reg, m_last_reg); end
        n_cmp++;
        if (rf_data_in !== m_last_data) begin n_bad++; $display("FAIL rf_data_in t=%0t got %h exp %h", $time, rf_data_in, m_last_data); end
        n_cmp++;
        if (busy !== m_busy) begin n_bad++; $display("FAIL busy t=%0t got %h exp %h", $time, busy, m_busy); end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive_cycle(0, 1, 3'd1, 32'h1, 1, 3'd2, 32'h2, 1, 3'd4);
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        n_cmp++;
        if (busy !== 8'h00 || rf_we !== 1'b0) begin
            n_bad++; $display("FAIL reset_state busy=%h rf_we=%b exp 00/0", busy, rf_we);
        end
    endtask

    task automatic test_only_a();
        drive_cycle(1, 1, 3'd1, 32'hffff0000, 0, 0, 0, 0, 0);
        n_cmp++;
        if (rf_we !== 1'b1 || rf_write_reg !== 3'd1 || rf_data_in !== 32'hffff0000) begin
            n_bad++; $display("FAIL only_a_write we=%b reg=%0d data=%h exp 1/1/ffff0000", rf_we, rf_write_reg, rf_data_in);
        end
        idle(1);
    endtask

    task automatic test_contention();
        drive_cycle(0, 1, 3'd0, 32'hfffffffe, 1, 3'd2, 32'h0000ffff, 0, 0);
        drive_cycle(1, 1, 3'd0, 32'hfffffffe, 1, 3'd2, 32'h0000ffff, 0, 0);
        n_cmp++;
        if (rf_write_reg !== 3'd0 || rf_data_in !== 32'hfffffffe) begin
            n_bad++; $display("FAIL contention_first reg=%0d data=%h exp 0/fffffffe", rf_write_reg, rf_data_in);
        end
        drive_cycle(1, 1, 3'd0, 32'hfffffffe, 1, 3'd2, 32'h0000ffff, 0, 0);
        n_cmp++;
        if (rf_write_reg !== 3'd2 || rf_data_in !== 32'h0000ffff) begin
            n_bad++; $display("FAIL contention_second reg=%0d data=%h exp 2/0000ffff", rf_write_reg, rf_data_in);
        end
        for (int i = 0; i < 4; i++)
            drive_cycle(1, 1, 3'd0, 32'hfffffffe, 1, 3'd2, 32'h0000ffff, 0, 0);
        // Uncontended grants must not move the pointer
        drive_cycle(1, 0, 0, 0, 1, 3'd6, 32'h66, 0, 0);
        drive_cycle(1, 0, 0, 0, 1, 3'd6, 32'h67, 0, 0);
        drive_cycle(1, 1, 3'd7, 32'h77, 1, 3'd7, 32'h78, 0, 0);
        drive_cycle(1, 1, 3'd7, 32'h77, 1, 3'd7, 32'h78, 0, 0);
        idle(1);
    endtask

    task automatic test_scoreboard();
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 1, 3'd3);
        n_cmp++;
        if (busy !== 8'h08) begin n_bad++; $display("FAIL claim3_busy got %h exp 08", busy); end
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 1, 3'd3);
        drive_cycle(1, 0, 0, 0, 1, 3'd3, 32'h33, 0, 0);
        n_cmp++;
        if (busy !== 8'h00) begin n_bad++; $display("FAIL clear3_busy got %h exp 00", busy); end
        // Write to a non-busy register leaves scoreboard alone
        drive_cycle(1, 1, 3'd4, 32'h44, 0, 0, 0, 0, 0);
    endtask

    task automatic test_claim_clear();
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 1, 3'd5);
        drive_cycle(1, 1, 3'd5, 32'h55, 0, 0, 0, 1, 3'd5);
        n_cmp++;
        if (busy[5] !== 1'b0) begin n_bad++; $display("FAIL busy5_cleared got %b exp 0", busy[5]); end
        drive_cycle(1, 1, 3'd5, 32'h56, 0, 0, 0, 1, 3'd5);
        n_cmp++;
        if (busy[5] !== 1'b1) begin n_bad++; $display("FAIL busy5_claim_wins got %b exp 1", busy[5]); end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1, 1, 3'd4, 32'hab, 0, 0, 0, 1, 3'd6);
        drive_cycle(0, 1, 3'd2, 32'hcd, 0, 0, 0, 0, 0);
        n_cmp++;
        if (rf_we !== 1'b0 || busy !== 8'h00) begin
            n_bad++; $display("FAIL reset_mid we=%b busy=%h exp 0/00", rf_we, busy);
        end
        idle(1);
    endtask

    // Random traffic with requesters holding requests until granted
    task automatic test_random();
        logic ap = 0, bp = 0;
        logic [AW-1:0] ar = 0, br = 0, cr;
        logic [DW-1:0] ad = 0, bd = 0;
        int aw = 0, bw = 0;
        for (int i = 0; i < 60; i++) begin
            if (!ap && $urandom_range(0, 1) == 1) begin ap = 1; ar = AW'($urandom); ad = $urandom; end
            if (!bp && $urandom_range(0, 1) == 1) begin bp = 1; br = AW'($urandom); bd = $urandom; end
            cr = AW'($urandom);
            drive_cycle(1, ap, ar, ad, bp, br, bd, 1'($urandom), cr);
            if (ap) aw++;
            if (bp) bw++;
            if (g_a) begin ap = 0; aw = 0; end
            if (g_b) begin bp = 0; bw = 0; end
            n_cmp++;
            if (aw > 1 || bw > 1) begin
                n_bad++; $display("FAIL starvation wait_a=%0d wait_b=%0d exp <=1 ungranted", aw, bw);
            end
        end
        idle(1);
    endtask

    initial begin
        rst = 0; a_valid = 0; b_valid = 0; claim_valid = 0;
        a_reg = 0; b_reg = 0; claim_reg = 0; a_data = 0; b_data = 0;
        m_prio_b = 0; m_busy = 0; m_last_reg = 0; m_last_data = 0;
        g_a = 0; g_b = 0;
        @(negedge clk);
        test_reset();
        test_only_a();
        test_contention();
        test_scoreboard();
        test_claim_clear();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_rf_wr_arb

`default_nettype wire
